// File: rtl/rfaludm_pkg.sv
// Shared types and encodings for the multi-cycle LEGv8 regfile/ALU/data-memory block.
package rfaludm_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RF   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    // Control word captured when an operation is accepted.
    typedef struct packed {
        logic [1:0]  alu_op;
        logic [10:0] opcode;
        logic        reg_write;
        logic        alu_src;
        logic        mem_write;
        logic        mem_read;
        logic        mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/legv8_alu_ctl.sv
// LEGv8 ALU with its ALUOp/opcode control decode; unknown R-type opcodes yield 0.
module legv8_alu_ctl
    import rfaludm_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]        alu_op,
    input  logic [10:0]       opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    always_comb begin
        y = '0;
        case (alu_op)
            ALUOP_ADD:   y = a + b;
            ALUOP_PASSB: y = b;
            ALUOP_RTYPE: begin
                case (opcode)
                    OPC_ADD: y = a + b;
                    OPC_SUB: y = a - b;
                    OPC_AND: y = a & b;
                    OPC_ORR: y = a | b;
                    default: y = '0;
                endcase
            end
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/rfaludm_mc.sv
// Multi-cycle register file + ALU + data memory (IDLE->RF->EX->[MEM]->WB).
// Define RFALUDM_XZR_EN to make register NREGS-1 a hardwired zero register.
module rfaludm_mc
    import rfaludm_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int NREGS     = 32,
    parameter int MEM_WORDS = 128,
    parameter int MEM_LAT   = 2,
    localparam int RA_W     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        ALUOp,
    input  logic [10:0]       Opcode_field,
    input  logic              RegWrite,
    input  logic              ALUSrc,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              MemtoReg,
    input  logic [RA_W-1:0]   rd_addr_1,
    input  logic [RA_W-1:0]   rd_addr_2,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [8:0]        displacement,
    output logic              busy,
    output logic              done,
    output logic              Zero,
    output logic [DATA_W-1:0] result,
    output logic              mem_fault
);

`ifdef RFALUDM_XZR_EN
    localparam bit XZR_EN = 1'b1;
`else
    localparam bit XZR_EN = 1'b0;
`endif

    localparam int              NB       = DATA_W / 8;
    localparam int              MA_W     = $clog2(MEM_WORDS);
    localparam logic [3:0]      LAT_LAST = 4'(MEM_LAT - 1);
    localparam logic [RA_W-1:0] XZR_ADDR = RA_W'(NREGS - 1);

    state_t state_q, state_d;

    ctrl_t             ctrl_q;
    logic [RA_W-1:0]   ra1_q, ra2_q, wa_q;
    logic [8:0]        disp_q;
    logic [DATA_W-1:0] op_a, op_b, st_data, alu_q, alu_y;
    logic              alu_zero;
    logic [3:0]        mem_cnt;
    logic              mem_last, is_mem, acc_fault;
    logic [DATA_W-1:0] rd1, rd2, sext, word_idx, ld_data;
    logic [MA_W-1:0]   mem_idx;

    logic [DATA_W-1:0] rf  [NREGS];
    logic [DATA_W-1:0] mem [MEM_WORDS];

    legv8_alu_ctl #(.DATA_W(DATA_W)) u_alu (
        .alu_op (ctrl_q.alu_op),
        .opcode (ctrl_q.opcode),
        .a      (op_a),
        .b      (op_b),
        .y      (alu_y),
        .zero   (alu_zero)
    );

    assign rd1  = (XZR_EN && ra1_q == XZR_ADDR) ? '0 : rf[ra1_q];
    assign rd2  = (XZR_EN && ra2_q == XZR_ADDR) ? '0 : rf[ra2_q];
    assign sext = {{(DATA_W-9){disp_q[8]}}, disp_q};

    assign is_mem    = ctrl_q.mem_read | ctrl_q.mem_write;
    assign mem_last  = (mem_cnt == LAT_LAST);
    assign word_idx  = alu_q / DATA_W'(NB);
    assign mem_idx   = word_idx[MA_W-1:0];
    assign acc_fault = ((alu_q % DATA_W'(NB)) != '0) || (word_idx >= DATA_W'(MEM_WORDS));
    // A store wins over a simultaneous load, so the load side returns 0.
    assign ld_data   = (ctrl_q.mem_read && !ctrl_q.mem_write && !acc_fault) ? mem[mem_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_RF;
            end
            S_RF:  state_d = S_EX;
            S_EX:  state_d = is_mem ? S_MEM : S_WB;
            S_MEM: if (mem_last) state_d = S_WB;
            S_WB: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            ra1_q     <= '0;
            ra2_q     <= '0;
            wa_q      <= '0;
            disp_q    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            st_data   <= '0;
            alu_q     <= '0;
            mem_cnt   <= '0;
            result    <= '0;
            Zero      <= 1'b0;
            mem_fault <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    ctrl_q <= '{alu_op: ALUOp, opcode: Opcode_field, reg_write: RegWrite,
                                alu_src: ALUSrc, mem_write: MemWrite, mem_read: MemRead,
                                mem_to_reg: MemtoReg};
                    ra1_q  <= rd_addr_1;
                    ra2_q  <= rd_addr_2;
                    wa_q   <= wr_addr;
                    disp_q <= displacement;
                end
                S_RF: begin
                    op_a    <= rd1;
                    op_b    <= ctrl_q.alu_src ? sext : rd2;
                    st_data <= rd2;
                end
                S_EX: begin
                    alu_q   <= alu_y;
                    mem_cnt <= '0;
                    if (!is_mem) begin
                        result    <= ctrl_q.mem_to_reg ? '0 : alu_y;
                        Zero      <= alu_zero;
                        mem_fault <= 1'b0;
                    end
                end
                S_MEM: begin
                    mem_cnt <= mem_cnt + 4'd1;
                    if (mem_last) begin
                        result    <= ctrl_q.mem_to_reg ? ld_data : alu_q;
                        Zero      <= (alu_q == '0);
                        mem_fault <= acc_fault;
                    end
                end
                S_WB: begin
                    // mem_fault already holds this operation's fault status here.
                    if (ctrl_q.reg_write && !mem_fault && !(XZR_EN && wa_q == XZR_ADDR))
                        rf[wa_q] <= result;
                end
                default: ;
            endcase
        end
    end

    // Memory is deliberately left out of reset; only the store path is gated by it.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_MEM && mem_last && ctrl_q.mem_write && !acc_fault)
            mem[mem_idx] <= st_data;
    end

endmodule

// File: tb/tb_rfaludm_mc.sv
// Directed table-driven bench for rfaludm_mc plus hand sequences for start-hold and mid-op reset.
module tb_rfaludm_mc;
    import rfaludm_pkg::*;

    localparam int DATA_W  = 64;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  ALUOp;
    logic [10:0] Opcode_field;
    logic        RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg;
    logic [4:0]  rd_addr_1, rd_addr_2, wr_addr;
    logic [8:0]  displacement;
    logic        busy, done, Zero, mem_fault;
    logic [63:0] result;

    rfaludm_mc #(.DATA_W(DATA_W), .NREGS(32), .MEM_WORDS(128), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .Opcode_field(Opcode_field),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead),
        .MemtoReg(MemtoReg), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .wr_addr(wr_addr),
        .displacement(displacement), .busy(busy), .done(done), .Zero(Zero),
        .result(result), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  aluop;
        logic [10:0] opc;
        logic        src, rw, mw, mr, m2r;
        logic [4:0]  ra1, ra2, wa;
        logic [8:0]  disp;
        int          lat;
        logic [63:0] res;
        logic        zero, fault;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [10:0] opc, input logic src,
                                input logic rw, input logic mw, input logic mr, input logic m2r,
                                input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] wa,
                                input logic [8:0] disp, input logic [63:0] res, input logic zero,
                                input logic fault);
        vec_t v;
        v.aluop = op; v.opc = opc; v.src = src; v.rw = rw; v.mw = mw; v.mr = mr; v.m2r = m2r;
        v.ra1 = ra1; v.ra2 = ra2; v.wa = wa; v.disp = disp;
        v.lat = (mw || mr) ? 3 + MEM_LAT : 3;
        v.res = res; v.zero = zero; v.fault = fault;
        return v;
    endfunction

    // Helpers: load immediate, read a register, R-type, load, store.
    task automatic imm(input logic [4:0] wa, input logic [8:0] d, input logic [63:0] e);
        tbl.push_back(mk(ALUOP_PASSB, 11'd0, 1, 1, 0, 0, 0, 5'd0, 5'd0, wa, d, e, e == 0, 0));
    endtask
    task automatic rd(input logic [4:0] r, input logic [63:0] e);
        tbl.push_back(mk(ALUOP_PASSB, 11'd0, 0, 0, 0, 0, 0, 5'd0, r, 5'd0, 9'd0, e, e == 0, 0));
    endtask
    task automatic rop(input logic [10:0] opc, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] wa, input logic rw, input logic [63:0] e);
        tbl.push_back(mk(ALUOP_RTYPE, opc, 0, rw, 0, 0, 0, a, b, wa, 9'd0, e, e == 0, 0));
    endtask
    task automatic ldur(input logic [4:0] base, input logic [8:0] d, input logic [4:0] wa,
                        input logic [63:0] e, input logic f);
        tbl.push_back(mk(ALUOP_ADD, 11'd0, 1, 1, 0, 1, 1, base, 5'd0, wa, d, e, 0, f));
    endtask
    task automatic stur(input logic [4:0] base, input logic [4:0] data, input logic [8:0] d,
                        input logic [63:0] addr);
        tbl.push_back(mk(ALUOP_ADD, 11'd0, 1, 0, 1, 0, 0, base, data, 5'd0, d, addr, 0, 0));
    endtask

    task automatic drive(input vec_t v);
        ALUOp = v.aluop; Opcode_field = v.opc; ALUSrc = v.src; RegWrite = v.rw;
        MemWrite = v.mw; MemRead = v.mr; MemtoReg = v.m2r;
        rd_addr_1 = v.ra1; rd_addr_2 = v.ra2; wr_addr = v.wa; displacement = v.disp;
    endtask

    task automatic scramble();
        ALUOp = 2'($urandom); Opcode_field = 11'($urandom); ALUSrc = 1'($urandom);
        RegWrite = 1'($urandom); MemWrite = 1'($urandom); MemRead = 1'($urandom);
        MemtoReg = 1'($urandom); rd_addr_1 = 5'($urandom); rd_addr_2 = 5'($urandom);
        wr_addr = 5'($urandom); displacement = 9'($urandom);
    endtask

    task automatic apply(input vec_t v, input int id);
        int cyc;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        scramble();
        cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            if (done) begin cyc = n; break; end
            @(negedge clk);
        end
        chk("latency", id, 64'(cyc), 64'(v.lat));
        chk("result", id, result, v.res);
        chk("zero", id, 64'(Zero), 64'(v.zero));
        chk("mem_fault", id, 64'(mem_fault), 64'(v.fault));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] x31_exp;
        vec_t        v;
        int          cyc, dcnt;
        logic [63:0] r_sub;
        logic        z_sub;

`ifdef RFALUDM_XZR_EN
        x31_exp = 64'h0;
`else
        x31_exp = 64'h55;
`endif

        reset = 1'b1; start = 1'b0;
        drive(mk(2'b00, 11'd0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 9'd0, 64'd0, 0, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 0, 64'(busy), 64'd0);
        chk("rst_done", 0, 64'(done), 64'd0);
        chk("rst_result", 0, result, 64'd0);
        chk("rst_zero", 0, 64'(Zero), 64'd0);
        chk("rst_fault", 0, 64'(mem_fault), 64'd0);

        imm(5'd1, 9'd5, 64'd5);
        imm(5'd2, 9'd7, 64'd7);
        rop(OPC_ADD, 5'd1, 5'd2, 5'd3, 1, 64'd12);
        rd(5'd3, 64'd12);
        rop(OPC_AND, 5'd1, 5'd2, 5'd0, 0, 64'd5);
        rop(OPC_ORR, 5'd1, 5'd2, 5'd0, 0, 64'd7);
        rop(11'h000, 5'd1, 5'd2, 5'd0, 0, 64'd0);
        rop(OPC_SUB, 5'd1, 5'd2, 5'd0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        tbl.push_back(mk(ALUOP_ADD, 11'd0, 1, 0, 0, 0, 0, 5'd1, 5'd0, 5'd0, 9'h1FA,
                         64'hFFFF_FFFF_FFFF_FFFF, 0, 0));
        imm(5'd11, 9'h0FF, 64'd255);
        imm(5'd11, 9'h100, 64'hFFFF_FFFF_FFFF_FF00);
        rd(5'd11, 64'hFFFF_FFFF_FFFF_FF00);
        // X4 = 0xDE << 8 by doubling, then + 0xAD
        imm(5'd4, 9'h0DE, 64'hDE);
        for (int k = 1; k <= 8; k++) rop(OPC_ADD, 5'd4, 5'd4, 5'd4, 1, 64'hDE << k);
        imm(5'd6, 9'h0AD, 64'hAD);
        rop(OPC_ADD, 5'd4, 5'd6, 5'd4, 1, 64'hDEAD);
        stur(5'd0, 5'd4, 9'd16, 64'd16);
        ldur(5'd0, 9'd16, 5'd5, 64'hDEAD, 0);
        rd(5'd5, 64'hDEAD);
        imm(5'd8, 9'h077, 64'h77);
        ldur(5'd0, 9'd12, 5'd8, 64'd0, 1);
        rd(5'd8, 64'h77);
        imm(5'd9, 9'd128, 64'd128);
        rop(OPC_ADD, 5'd9, 5'd9, 5'd9, 1, 64'd256);
        rop(OPC_ADD, 5'd9, 5'd9, 5'd9, 1, 64'd512);
        rop(OPC_ADD, 5'd9, 5'd9, 5'd9, 1, 64'd1024);
        ldur(5'd9, 9'd0, 5'd8, 64'd0, 1);
        rd(5'd8, 64'h77);
        stur(5'd9, 5'd4, 9'h1F8, 64'd1016);
        ldur(5'd9, 9'h1F8, 5'd10, 64'hDEAD, 0);
        // load and store together at 32: store of X2 wins, load data reads as 0
        tbl.push_back(mk(ALUOP_ADD, 11'd0, 1, 0, 1, 1, 1, 5'd0, 5'd2, 5'd0, 9'd32, 64'd0, 0, 0));
        ldur(5'd0, 9'd32, 5'd10, 64'd7, 0);
        stur(5'd0, 5'd2, 9'd24, 64'd24);
        imm(5'd31, 9'h055, 64'h55);
        rd(5'd31, x31_exp);
        imm(5'd1, 9'd9, 64'd9);
        imm(5'd2, 9'd9, 64'd9);

        foreach (tbl[i]) apply(tbl[i], i + 1);

        // SUB 9-9 with start held high through busy; the competing op must not run
        @(negedge clk);
        drive(mk(ALUOP_RTYPE, OPC_SUB, 0, 1, 0, 0, 0, 5'd1, 5'd2, 5'd12, 9'd0, 64'd0, 1, 0));
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(mk(ALUOP_PASSB, 11'd0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd7, 9'h033, 64'd0, 0, 0));
        cyc = 0; dcnt = 0; r_sub = '1; z_sub = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (done) begin
                cyc = n; dcnt++; r_sub = result; z_sub = Zero;
                start = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("hold_latency", 100, 64'(cyc), 64'd3);
        chk("hold_result", 100, r_sub, 64'd0);
        chk("hold_zero", 100, 64'(z_sub), 64'd1);
        @(negedge clk);
        chk("hold_idle", 100, 64'(busy), 64'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("hold_done_count", 100, 64'(dcnt), 64'd1);
        rd(5'd7, 64'd0);
        apply(tbl[tbl.size()-1], 101);

        // Reset in the first MEM cycle of a store of X4 to address 24
        @(negedge clk);
        drive(mk(ALUOP_ADD, 11'd0, 1, 0, 1, 0, 0, 5'd0, 5'd4, 5'd0, 9'd24, 64'd0, 0, 0));
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mem_busy", 200, 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 200, 64'(busy), 64'd0);
        chk("abort_done", 200, 64'(done), 64'd0);
        chk("abort_result", 200, result, 64'd0);
        chk("abort_fault", 200, 64'(mem_fault), 64'd0);
        rd(5'd4, 64'd0);
        apply(tbl[tbl.size()-1], 201);
        ldur(5'd0, 9'd24, 5'd1, 64'd7, 0);
        apply(tbl[tbl.size()-1], 202);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rfaludm_mc.md
RFALUDM_MC -- requirements
Module: rfaludm_mc

Interface
REQ-001 Parameter DATA_W, 64, datapath and register width; multiple of 8, at least 16.
REQ-002 Parameter NREGS, 32, register count; power of two; RA_W = clog2(NREGS).
REQ-003 Parameter MEM_WORDS, 128, data-memory depth in DATA_W words.
REQ-004 Parameter MEM_LAT, 2, data-memory wait cycles; range 1..15.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 start  in  1  begins one operation when sampled high in IDLE.
REQ-008 ALUOp  in  2  00 add, 01 pass-B, 10 R-type decode via Opcode_field.
REQ-009 Opcode_field  in  11  ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
REQ-010 RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg  in  1 each  controls with the usual LEGv8 meaning.
REQ-011 rd_addr_1, rd_addr_2, wr_addr  in  RA_W each  register addresses.
REQ-012 displacement  in  9  signed offset; sign-extended to DATA_W when ALUSrc=1.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 done  out  1  one-cycle pulse in WB.
REQ-015 Zero  out  1  registered flag; 1 when the ALU result equals 0.
REQ-016 result  out  DATA_W  registered writeback value: ALU result, or load data when MemtoReg=1.
REQ-017 mem_fault  out  1  registered flag; 1 when the last memory access was out of range or misaligned.

Function
REQ-018 FSM states: IDLE -> RF -> EX -> (MEM if MemRead or MemWrite) -> WB -> IDLE.
REQ-019 All inputs except clk and reset are captured on the edge that accepts start; the block ignores later changes until the next accept.
REQ-020 start is ignored while busy=1; start is not queued.
REQ-021 Latency from the accepting edge: non-memory operation, done high in cycle 3; memory operation, done high in cycle 3+MEM_LAT.
REQ-022 RF stage: registers read operands, using their values as written by any previous operation.
REQ-023 EX stage: ALU computes A op B, where B is the sign-extended displacement when ALUSrc=1; unknown Opcode_field under ALUOp=10 gives result 0.
REQ-024 Arithmetic wraps modulo 2^DATA_W; no carry or overflow outputs.
REQ-025 Memory byte address = ALU result; word index = address / (DATA_W/8).
REQ-026 An access faults when the address is not word-aligned or the index is >= MEM_WORDS.
REQ-027 A faulting access writes nothing to memory, returns load data 0, and suppresses the register write.
REQ-028 The MEM stage holds for exactly MEM_LAT cycles; a store commits on the last MEM cycle.
REQ-029 WB stage: register write occurs when RegWrite=1 and no fault; result, Zero and mem_fault update in this cycle.
REQ-030 MemRead=1 and MemWrite=1 together: the store takes priority and the load data is 0.

Reset
REQ-031 Reset forces IDLE, all registers 0, all outputs 0; memory contents are not cleared.
REQ-032 Reset asserted mid-operation aborts it: no pending register write or store commits.

Configuration
REQ-033 With RFALUDM_XZR_EN defined, register NREGS-1 always reads 0 and writes to it are discarded.
REQ-034 Without RFALUDM_XZR_EN, register NREGS-1 is an ordinary register.

Structure
REQ-035 Package rfaludm_pkg holds the FSM state enum, the ALUOp encodings and the four opcode constants.
REQ-036 The ALU and its control decode form one sub-module, legv8_alu_ctl.

Verification
REQ-037 After reset, ADD (ALUOp=10) with X1=5 and X2=7 writing X3 -> done in cycle 3, result=12, Zero=0, X3=12.
REQ-038 SUB with X1 = X2 = 9 -> result=0, Zero=1; a second start held high during busy is ignored.
REQ-039 STUR X4=0xDEAD at address 16, then LDUR from 16 into X5 (MEM_LAT=2) -> done in cycle 5, X5=0xDEAD, mem_fault=0.
REQ-040 LDUR at address 12 (misaligned), then at address 8*MEM_WORDS -> mem_fault=1, result=0, destination register unchanged.
REQ-041 Reset pulsed in the MEM cycle of a store to address 24 -> memory word 3 unchanged, busy=0 next cycle.
REQ-042 With RFALUDM_XZR_EN, write 0x55 to X31 and then read it -> 0; without the macro -> 0x55.
